// File: rtl/sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_drawer
// Purpose  : Pixel-drawing engine. On a one-cycle draw_bg / draw_char request
//            it latches the sprite's top-left corner and sweeps a
//            SPRITE_W x SPRITE_H box in raster order, one pixel per cycle.
//            BG mode restores background pixels from the background ROM;
//            CHAR mode plots sprite ROM pixels, skipping TRANSPARENT ones.
//            Off-screen pixels are swept (and timed) but never plotted.
// Ports    : clock, reset        - clock, synchronous active-high reset
//            draw_bg, draw_char  - one-cycle requests (BG wins if both)
//            x_in, y_in          - sprite top-left, sampled on acceptance
//            bg_addr / bg_data   - background ROM port (1-cycle latency)
//            spr_addr / spr_data - sprite ROM port (1-cycle latency)
//            vga_x/y/colour/plot - VGA adapter plot port
//            busy                - request in progress
//            done_bg, done_char  - one-cycle completion pulses
// Revision : 1.0 - initial release
// ============================================================================
module sprite_drawer #(
  parameter int                    SPRITE_W    = 8,
  parameter int                    SPRITE_H    = 8,
  parameter int                    SPR_AW      = 6,
  parameter int                    COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0]   TRANSPARENT = '0,
  parameter int                    SCREEN_W    = 320,
  parameter int                    SCREEN_H    = 240
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                draw_bg,
  input  logic                draw_char,
  input  logic [8:0]          x_in,
  input  logic [7:0]          y_in,
  output logic [16:0]         bg_addr,
  input  logic [COLOUR_W-1:0] bg_data,
  output logic [SPR_AW-1:0]   spr_addr,
  input  logic [COLOUR_W-1:0] spr_data,
  output logic [8:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done_bg,
  output logic                done_char
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;

  // Latched request context
  logic [8:0]       x0;
  logic [7:0]       y0;
  logic             mode_char;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // One-stage pipeline aligning pixel attributes with ROM data
  logic             p_valid;
  logic             p_clip;
  logic [8:0]       p_x;
  logic [7:0]       p_y;

  // Combinational pixel coordinates, wide enough that they never wrap
  logic [9:0]       px;
  logic [8:0]       py;
  logic             clip;
  logic             issue;
  logic             request;
  logic             col_last;
  logic             last_pix;

  assign request  = draw_bg | draw_char;
  assign col_last = (col == COL_W'(SPRITE_W - 1));
  assign last_pix = col_last && (row == ROW_W'(SPRITE_H - 1));
  assign px       = {1'b0, x0} + 10'(col);
  assign py       = {1'b0, y0} + 9'(row);
  assign clip     = (px >= 10'(SCREEN_W)) || (py >= 9'(SCREEN_H));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (request)  state_next = S_SWEEP;
      S_SWEEP: if (last_pix) state_next = S_FLUSH;
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    issue     = (state == S_SWEEP);
    busy      = (state != S_IDLE);
    done_bg   = (state == S_DONE) && !mode_char;
    done_char = (state == S_DONE) &&  mode_char;
  end

  // --------------------------------------------------------------------------
  // Sweep counters, request latch and plot pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      x0        <= '0;
      y0        <= '0;
      mode_char <= 1'b0;
      col       <= '0;
      row       <= '0;
      p_valid   <= 1'b0;
      p_clip    <= 1'b0;
      p_x       <= '0;
      p_y       <= '0;
    end else begin
      if (state == S_IDLE) begin
        col <= '0;
        row <= '0;
        if (request) begin
          x0        <= x_in;
          y0        <= y_in;
          // BG has priority when both requests arrive together
          mode_char <= !draw_bg;
        end
      end else if (issue) begin
        if (col_last) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      p_valid <= issue;
      p_clip  <= issue & clip;
      // Only the low bits are kept; anything wider is clipped anyway
      p_x     <= issue ? px[8:0] : '0;
      p_y     <= issue ? py[7:0] : '0;
    end
  end

  // ROM addresses are presented during the issue cycle, zero otherwise
  always_comb begin
    bg_addr  = '0;
    spr_addr = '0;
    if (issue) begin
      bg_addr  = 17'(py) * 17'(SCREEN_W) + 17'(px);
      spr_addr = SPR_AW'(row) * SPR_AW'(SPRITE_W) + SPR_AW'(col);
    end
  end

  // Plot port: ROM data arrives aligned with the pipelined pixel attributes
  always_comb begin
    vga_x      = p_x;
    vga_y      = p_y;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (p_valid) begin
      vga_colour = mode_char ? spr_data : bg_data;
      vga_plot   = !p_clip && (!mode_char || (spr_data != TRANSPARENT));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_drawer
// Purpose  : Self-checking bench for sprite_drawer. ROMs are modelled as
//            1-cycle synchronous memories; expected plots are derived from
//            screen geometry (box, clipping, transparency) with timestamps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_drawer;

  logic        clock = 1'b0;
  logic        reset;
  logic        draw_bg;
  logic        draw_char;
  logic [8:0]  x_in;
  logic [7:0]  y_in;
  logic [16:0] bg_addr;
  logic [2:0]  bg_data;
  logic [5:0]  spr_addr;
  logic [2:0]  spr_data;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done_bg;
  logic        done_char;

  sprite_drawer dut (
    .clock(clock), .reset(reset), .draw_bg(draw_bg), .draw_char(draw_char),
    .x_in(x_in), .y_in(y_in), .bg_addr(bg_addr), .bg_data(bg_data),
    .spr_addr(spr_addr), .spr_data(spr_data), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .done_bg(done_bg), .done_char(done_char)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int         t;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } plot_t;

  plot_t exp_q[$];
  plot_t obs_q[$];
  int    dbg_q[$];
  int    dch_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  logic [2:0] spr_mem [64];

  function automatic logic [2:0] bg_fn(input logic [16:0] a);
    logic [16:0] h;
    h = a ^ (a >> 3) ^ (a >> 7) ^ (a >> 11);
    return h[2:0];
  endfunction

  // Synchronous ROM models
  always @(posedge clock) begin
    bg_data  <= bg_fn(bg_addr);
    spr_data <= spr_mem[spr_addr];
  end

  // Monitor: sample away from the active edge
  always @(negedge clock) begin
    if (vga_plot)  obs_q.push_back('{cyc, vga_x, vga_y, vga_colour});
    if (done_bg)   dbg_q.push_back(cyc);
    if (done_char) dch_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: appends the plots a request at cycle t must produce
  task automatic add_expected(input int t, input int x0, input int y0, input bit is_char);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int px, py;
        logic [2:0] col;
        px = x0 + c;
        py = y0 + r;
        if (px < 320 && py < 240) begin
          col = is_char ? spr_mem[r*8 + c] : bg_fn(17'(py*320 + px));
          if (!(is_char && col == 3'd0))
            exp_q.push_back('{t + 2 + r*8 + c, 9'(px), 8'(py), col});
        end
      end
    end
  endtask

  task automatic fill_spr(input int nzero);
    int k;
    for (int i = 0; i < 64; i++) spr_mem[i] = 3'($urandom_range(1, 7));
    k = 0;
    while (k < nzero) begin
      int idx;
      idx = $urandom_range(0, 63);
      if (spr_mem[idx] != 3'd0) begin
        spr_mem[idx] = 3'd0;
        k++;
      end
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    dbg_q.delete();
    dch_q.delete();
    exp_q.delete();
  endtask

  // Caller is at a negedge; request is high for the current cycle t
  task automatic pulse(input bit b, input bit c, input int x, input int y, output int t);
    draw_bg   = b;
    draw_char = c;
    x_in      = 9'(x);
    y_in      = 8'(y);
    t         = cyc;
    @(negedge clock);
    draw_bg   = 1'b0;
    draw_char = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({vga_plot, busy, done_bg, done_char, bg_addr, spr_addr, vga_x, vga_y, vga_colour} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got plot=%b busy=%b dbg=%b dch=%b bga=%0d spa=%0d x=%0d y=%0d c=%0d, required all 0",
               vga_plot, busy, done_bg, done_char, bg_addr, spr_addr, vga_x, vga_y, vga_colour);
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({vga_plot, busy, done_bg, done_char} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got plot/busy/dbg/dch=%b required 0000",
               {vga_plot, busy, done_bg, done_char});
    end
  endtask

  task automatic test_bg_basic();
    int t;
    clear_obs();
    pulse(1'b1, 1'b0, 1, 16, t);
    add_expected(t, 1, 16, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL bg_busy_start: got %b required 1", busy); end
    wait_until(t + 66);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL bg_busy_end: got %b required 1", busy); end
    wait_until(t + 67);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL bg_busy_after: got %b required 0", busy); end
    wait_until(t + 70);
    n_cmp++;
    if (obs_q.size() != 64 || exp_q.size() != 64) begin
      n_err++; $display("FAIL bg_plot_count: got %0d required 64", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bg_plot[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 66 || dch_q.size() != 0) begin
      n_err++;
      $display("FAIL bg_done: got %0d done_bg (first at T+%0d), %0d done_char; required 1 at T+66, 0",
               dbg_q.size(), (dbg_q.size() > 0) ? dbg_q[0] - t : -1, dch_q.size());
    end
  endtask

  task automatic test_char();
    int t;
    clear_obs();
    fill_spr(10);
    pulse(1'b0, 1'b1, 100, 50, t);
    add_expected(t, 100, 50, 1'b1);
    wait_until(t + 70);
    n_cmp++;
    if (obs_q.size() != 54 || exp_q.size() != 54) begin
      n_err++; $display("FAIL char_plot_count: got %0d required 54", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL char_plot[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dch_q.size() != 1 || dch_q[0] != t + 66 || dbg_q.size() != 0) begin
      n_err++;
      $display("FAIL char_done: got %0d done_char, %0d done_bg; required 1 done_char at T+66",
               dch_q.size(), dbg_q.size());
    end
  endtask

  task automatic test_clip();
    int t;
    clear_obs();
    pulse(1'b1, 1'b0, 316, 236, t);
    add_expected(t, 316, 236, 1'b0);
    wait_until(t + 70);
    n_cmp++;
    if (obs_q.size() != 16 || exp_q.size() != 16) begin
      n_err++; $display("FAIL clip_plot_count: got %0d required 16", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL clip_plot[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 66) begin
      n_err++; $display("FAIL clip_done: got %0d done_bg pulses, required 1 at T+66", dbg_q.size());
    end
  endtask

  task automatic test_both();
    int t;
    clear_obs();
    fill_spr(5);
    pulse(1'b1, 1'b1, 30, 40, t);
    add_expected(t, 30, 40, 1'b0);
    wait_until(t + 10);
    draw_char = 1'b1;
    x_in      = 9'd200;
    y_in      = 8'd100;
    @(negedge clock);
    draw_char = 1'b0;
    wait_until(t + 140);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL both_plot_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL both_plot[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 66 || dch_q.size() != 0) begin
      n_err++;
      $display("FAIL both_done: got %0d done_bg, %0d done_char; required 1, 0", dbg_q.size(), dch_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, t2;
    clear_obs();
    pulse(1'b1, 1'b0, 60, 70, t);
    add_expected(t, 60, 70, 1'b0);
    wait_until(t + 20);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({vga_plot, busy} !== 2'b00) begin
      n_err++; $display("FAIL rst_mid_idle: got plot/busy=%b required 00", {vga_plot, busy});
    end
    wait_until(t + 25);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].t > t + 20) void'(exp_q.pop_back());
    n_cmp++;
    if (obs_q.size() != exp_q.size() || dbg_q.size() != 0 || dch_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_plots: got %0d plots %0d done; required %0d plots 0 done",
               obs_q.size(), dbg_q.size() + dch_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rst_mid_plot[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_obs();
    fill_spr(20);
    pulse(1'b0, 1'b1, 5, 5, t2);
    add_expected(t2, 5, 5, 1'b1);
    wait_until(t2 + 70);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || dch_q.size() != 1 || dch_q[0] != t2 + 66 || dbg_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_restart: got %0d plots %0d done_char; required %0d plots 1 done_char at T+66",
               obs_q.size(), dch_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rst_restart_plot[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, t_ign, t2;
    clear_obs();
    fill_spr(8);
    pulse(1'b1, 1'b0, 150, 120, t);
    add_expected(t, 150, 120, 1'b0);
    wait_until(t + 66);
    n_cmp++;
    if (done_bg !== 1'b1) begin n_err++; $display("FAIL b2b_done_bg_now: got %b required 1", done_bg); end
    pulse(1'b0, 1'b1, 200, 100, t_ign);
    pulse(1'b0, 1'b1, 40, 60, t2);
    add_expected(t2, 40, 60, 1'b1);
    wait_until(t2 + 140);
    n_cmp++;
    if (dbg_q.size() != 1 || dch_q.size() != 1 || dch_q[0] != t + 67 + 66) begin
      n_err++;
      $display("FAIL b2b_done: got %0d done_bg %0d done_char (first at T+%0d); required 1, 1 at T+133",
               dbg_q.size(), dch_q.size(), (dch_q.size() > 0) ? dch_q[0] - t : -1);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_plot_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_plot[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int t, x, y;
      bit is_char;
      clear_obs();
      fill_spr($urandom_range(0, 30));
      x       = $urandom_range(0, 511);
      y       = $urandom_range(0, 255);
      is_char = 1'($urandom_range(0, 1));
      if (n < 3) begin
        x = $urandom_range(300, 330);
        y = $urandom_range(225, 250);
      end
      pulse(!is_char, is_char, x, y, t);
      add_expected(t, x, y, is_char);
      wait_until(t + 70);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL rand%0d_plot_count (%0d,%0d,char=%b): got %0d required %0d",
                 n, x, y, is_char, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand%0d_plot[%0d]: got %h required %h", n, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if ((is_char ? dch_q.size() : dbg_q.size()) != 1 || (is_char ? dbg_q.size() : dch_q.size()) != 0 ||
          (is_char ? dch_q[0] : dbg_q[0]) != t + 66) begin
        n_err++;
        $display("FAIL rand%0d_done: got %0d done_bg %0d done_char, required one done_%s at T+66",
                 n, dbg_q.size(), dch_q.size(), is_char ? "char" : "bg");
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    draw_bg   = 1'b0;
    draw_char = 1'b0;
    x_in      = '0;
    y_in      = '0;
    for (int i = 0; i < 64; i++) spr_mem[i] = 3'd1;
    repeat (3) @(negedge clock);
    test_reset();
    test_bg_basic();
    test_char();
    test_clip();
    test_both();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
